// File: rtl/writeback_queue.sv
// writeback_queue
//   A small circular FIFO that sits between the write-back producer and the
//   register-file write port. Entries drain in arrival order whenever the
//   write port is free. Decode-stage reads can ask whether a queued write
//   targets their source register.
//
// Ports
//   clk            single clock, rising edge
//   areset         synchronous active-high reset
//   wb_valid/wb_rd/wb_data/wb_ready   producer handshake (rd == 0 is dropped)
//   rf_hold        register-file write port busy this cycle
//   WE3/A3/WD3     register-file write port, driven from the head entry
//   A1/A2          decode read addresses
//   pend1/pend2    a queued (stored) write targets A1 / A2
//   count          number of occupied entries
module writeback_queue #(
  parameter int width         = 32,
  parameter int address_lines = 5,
  parameter int depth         = 4
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       wb_valid,
  input  logic [address_lines-1:0]   wb_rd,
  input  logic [width-1:0]           wb_data,
  output logic                       wb_ready,
  input  logic                       rf_hold,
  output logic                       WE3,
  output logic [address_lines-1:0]   A3,
  output logic [width-1:0]           WD3,
  input  logic [address_lines-1:0]   A1,
  input  logic [address_lines-1:0]   A2,
  output logic                       pend1,
  output logic                       pend2,
  output logic [$clog2(depth):0]     count
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  // Every entry is compared against A1/A2 in parallel, so storage is kept
  // in registers rather than a RAM with a registered read port.
  logic [address_lines-1:0] rd_mem   [depth];
  logic [width-1:0]         data_mem [depth];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  logic push;
  logic pop;
  logic [depth-1:0] match1;
  logic [depth-1:0] match2;

  assign wb_ready = (count_reg < CW'(depth)) && !areset;
  assign WE3      = (count_reg != '0) && !rf_hold && !areset;
  assign A3       = rd_mem[head_reg];
  assign WD3      = data_mem[head_reg];
  assign count    = count_reg;

  // Writes to x0 complete the handshake but never occupy an entry.
  assign push = wb_valid && wb_ready && (wb_rd != '0);
  assign pop  = WE3;

  // An entry is occupied when its distance from the head (modulo depth,
  // which the pointer width gives for free) is below the count.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_match
      logic [PW-1:0] offset;
      logic          occupied;
      assign offset     = PW'(gi) - head_reg;
      assign occupied   = {1'b0, offset} < count_reg;
      assign match1[gi] = occupied && (rd_mem[gi] == A1);
      assign match2[gi] = occupied && (rd_mem[gi] == A2);
    end
  endgenerate

  assign pend1 = (|match1) && (A1 != '0);
  assign pend2 = (|match2) && (A2 != '0);

  always_ff @(posedge clk) begin
    if (areset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Entry contents are not reset; occupancy alone decides their meaning.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= wb_rd;
      data_mem[tail_reg] <= wb_data;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue
//   Directed bench for writeback_queue (width 32, 5 address bits, depth 4).
//   A vector table covers single write, x0 drop and fill-under-hold; hand
//   sequences cover steady state, pointer wrap and reset mid-operation.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        areset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        rf_hold;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        pend1;
  logic        pend2;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  writeback_queue #(.width(32), .address_lines(5), .depth(4)) dut (
    .clk(clk), .areset(areset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_hold(rf_hold), .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .pend1(pend1), .pend2(pend2), .count(count)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        hold;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_p1;
    logic        e_p2;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic v, logic [4:0] rd, logic [31:0] d, logic h,
                              logic [4:0] a1, logic [4:0] a2, logic er, logic ew,
                              logic [4:0] ea3, logic [31:0] ewd, logic ep1,
                              logic ep2, logic [2:0] ec);
    vec_t t;
    t.valid = v; t.rd = rd; t.data = d; t.hold = h; t.a1 = a1; t.a2 = a2;
    t.e_ready = er; t.e_we = ew; t.e_a3 = ea3; t.e_wd = ewd;
    t.e_p1 = ep1; t.e_p2 = ep2; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state for the wrap test
  logic [36:0] mq[$];
  int          mcnt;
  int          written;
  int          pushed;
  logic        exp_we;
  logic        exp_rdy;
  logic [36:0] ent;

  initial begin
    areset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    rf_hold = 1'b0; A1 = '0; A2 = '0;

    // ---- reset: ready and WE3 forced low ----
    tick();
    #1;
    chk("rst_ready", {63'd0, wb_ready}, 64'd0);
    chk("rst_we", {63'd0, WE3}, 64'd0);
    tick();
    areset = 1'b0;
    #1;
    chk("post_rst_count", {61'd0, count}, 64'd0);
    chk("post_rst_pend", {62'd0, pend1, pend2}, 64'd0);
    $display("reset: count=%0d ready=%0b", count, wb_ready);

    // ---- vector table: single write, x0 drop, fill under hold, drain ----
    //              v  rd  data          h  a1 a2 rdy we a3 wd            p1 p2 cnt
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 5, 0, 1, 0, 0, 0,            0, 0, 0);
    vecs[1]  = mk(0, 0, 0,            0, 5, 5, 1, 1, 5, 32'hDEADBEEF, 1, 1, 1);
    vecs[2]  = mk(0, 0, 0,            0, 5, 0, 1, 0, 0, 0,            0, 0, 0);
    vecs[3]  = mk(1, 0, 32'h1234,     0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
    vecs[5]  = mk(1, 1, 32'h11,       1, 1, 2, 1, 0, 0, 0,            0, 0, 0);
    vecs[6]  = mk(1, 2, 32'h22,       1, 1, 2, 1, 0, 0, 0,            1, 0, 1);
    vecs[7]  = mk(1, 3, 32'h33,       1, 1, 2, 1, 0, 0, 0,            1, 1, 2);
    vecs[8]  = mk(1, 4, 32'h44,       1, 4, 3, 1, 0, 0, 0,            0, 1, 3);
    vecs[9]  = mk(1, 7, 32'h77,       1, 4, 7, 0, 0, 0, 0,            1, 0, 4);
    vecs[10] = mk(1, 7, 32'h77,       0, 1, 7, 0, 1, 1, 32'h11,       1, 0, 4);
    vecs[11] = mk(0, 0, 0,            0, 1, 2, 1, 1, 2, 32'h22,       0, 1, 3);
    vecs[12] = mk(0, 0, 0,            0, 0, 0, 1, 1, 3, 32'h33,       0, 0, 2);
    vecs[13] = mk(0, 0, 0,            0, 0, 4, 1, 1, 4, 32'h44,       0, 1, 1);
    vecs[14] = mk(0, 0, 0,            0, 0, 4, 1, 0, 0, 0,            0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      wb_valid = vecs[i].valid; wb_rd = vecs[i].rd; wb_data = vecs[i].data;
      rf_hold = vecs[i].hold; A1 = vecs[i].a1; A2 = vecs[i].a2;
      #1;
      chk($sformatf("vec%0d_ready", i), {63'd0, wb_ready}, {63'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_we", i), {63'd0, WE3}, {63'd0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_a3", i), {59'd0, A3}, {59'd0, vecs[i].e_a3});
        chk($sformatf("vec%0d_wd3", i), {32'd0, WD3}, {32'd0, vecs[i].e_wd});
      end
      chk($sformatf("vec%0d_pend", i), {62'd0, pend1, pend2}, {62'd0, vecs[i].e_p1, vecs[i].e_p2});
      chk($sformatf("vec%0d_count", i), {61'd0, count}, {61'd0, vecs[i].e_cnt});
      $display("vec %0d: ready=%0b we=%0b a3=%0d wd3=%0h p1=%0b p2=%0b count=%0d",
               i, wb_ready, WE3, A3, WD3, pend1, pend2, count);
      tick();
    end

    // ---- steady state: one push per cycle, written one cycle later ----
    wb_valid = 1'b0; rf_hold = 1'b0; A1 = '0; A2 = '0;
    for (int i = 0; i < 7; i++) begin
      wb_valid = (i < 6);
      wb_rd    = 5'(i + 10);
      wb_data  = 32'hC000 + i;
      #1;
      if (i > 0) begin
        chk($sformatf("ss%0d_count", i), {61'd0, count}, 64'd1);
        chk($sformatf("ss%0d_we", i), {63'd0, WE3}, 64'd1);
        chk($sformatf("ss%0d_a3", i), {59'd0, A3}, 64'(i + 9));
        chk($sformatf("ss%0d_wd3", i), {32'd0, WD3}, 64'(32'hC000 + i - 1));
      end
      $display("steady %0d: we=%0b a3=%0d wd3=%0h count=%0d", i, WE3, A3, WD3, count);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    chk("ss_drained", {61'd0, count}, 64'd0);

    // ---- pointer wrap: 10 pushes, repeated rd values, hold pulses ----
    mcnt = 0; written = 0; pushed = 0;
    for (int cyc = 0; cyc < 60 && (pushed < 10 || mcnt != 0); cyc++) begin
      wb_valid = (pushed < 10);
      wb_rd    = 5'((pushed % 3) + 1);
      wb_data  = 32'hA000 + pushed;
      rf_hold  = (cyc % 3 == 1) || (cyc % 7 == 2);
      #1;
      exp_rdy = (mcnt < 4);
      exp_we  = (mcnt != 0) && !rf_hold;
      chk($sformatf("wrap%0d_ready", cyc), {63'd0, wb_ready}, {63'd0, exp_rdy});
      chk($sformatf("wrap%0d_we", cyc), {63'd0, WE3}, {63'd0, exp_we});
      if (exp_we) begin
        ent = mq[0];
        chk($sformatf("wrap%0d_entry", cyc), {27'd0, A3, WD3}, {27'd0, ent});
      end
      $display("wrap %0d: hold=%0b ready=%0b we=%0b a3=%0d wd3=%0h count=%0d",
               cyc, rf_hold, wb_ready, WE3, A3, WD3, count);
      tick();
      if (exp_we) begin
        void'(mq.pop_front());
        mcnt--;
        written++;
      end
      if (wb_valid && exp_rdy) begin
        mq.push_back({wb_rd, wb_data});
        mcnt++;
        pushed++;
      end
    end
    wb_valid = 1'b0; rf_hold = 1'b0;
    #1;
    chk("wrap_written", 64'(written), 64'd10);
    chk("wrap_count", {61'd0, count}, 64'd0);

    // ---- reset mid-operation: three queued entries discarded ----
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(20 + i); wb_data = 32'hB000 + i;
      tick();
    end
    wb_valid = 1'b0;
    #1;
    chk("mid_count", {61'd0, count}, 64'd3);
    areset = 1'b1; rf_hold = 1'b0; wb_valid = 1'b1; wb_rd = 5'd25;
    #1;
    chk("mid_rst_we", {63'd0, WE3}, 64'd0);
    chk("mid_rst_ready", {63'd0, wb_ready}, 64'd0);
    $display("mid reset: we=%0b ready=%0b", WE3, wb_ready);
    tick();
    areset = 1'b0; wb_valid = 1'b0; A1 = 5'd20; A2 = 5'd25;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("after_rst%0d_count", i), {61'd0, count}, 64'd0);
      chk($sformatf("after_rst%0d_we", i), {63'd0, WE3}, 64'd0);
      chk($sformatf("after_rst%0d_pend", i), {62'd0, pend1, pend2}, 64'd0);
      $display("after reset %0d: we=%0b count=%0d p1=%0b p2=%0b", i, WE3, count, pend1, pend2);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
